h14tx_pattgen: RTL and testbench
================================

# h14tx_pattgen

Video test-pattern source for the h14tx transmit path. Sits directly upstream of `h14tx_dvo`: it consumes the `x`/`y` raster coordinates the DVO stage produces and returns one registered RGB pixel per clock on `video`. A debounced push-button cycles through four patterns, switching only on frame boundaries, so the serialised output never shows a torn frame.

## Interface
Parameters:
- `BitWidth`, 11: width of `x`.
- `BitHeight`, 10: width of `y`.
- `ActiveW`, 1280: active pixels per line. Must be a multiple of 8.
- `ActiveH`, 720: active lines per frame.
- `DebounceCycles`, 1_000_000: cycles the synchronised button must hold a stable level before it is accepted.

Ports:
- `clk` input, 1: pixel clock. The single clock of the block.
- `rst_n` input, 1: reset. Synchronous and active-low.
- `btn` input, 1: raw button pin, asynchronous. High means pressed.
- `x` input, `BitWidth`: current column from `h14tx_dvo`.
- `y` input, `BitHeight`: current line from `h14tx_dvo`.
- `video` output, `video_t [2:0]`: pixel. `[2]`=R, `[1]`=G, `[0]`=B, 8 bits each.
- `pattern` output, `pattern_t`: currently active pattern, for debug and LEDs.

## Operation
Button path:
- `btn` passes through a 2-flop synchroniser, then `h14tx_debounce`.
- The debouncer counts consecutive cycles in which the synchronised level differs from the accepted level. At `DebounceCycles` it flips the accepted level. Any return to the accepted level clears the count.
- A 0→1 transition of the accepted level sets `pending`.

Frame start:
- `frame_start = (x==0 && y==0) && !(x_q==0 && y_q==0)`, where `x_q`/`y_q` hold the previous cycle's coordinates. It therefore asserts for exactly one cycle per frame.

Updates on `frame_start`:
- If `pending`, then `pattern` advances 0→1→2→3→0 and `pending` clears.
- `bar_pos` advances by 4. If `bar_pos+4 >= ActiveW`, it wraps to 0.
- The updated `pattern` and `bar_pos` values apply to the (0,0) pixel itself, so pixel generation uses the next-state values.
- A press accepted in the same cycle as `frame_start` counts as pending for that frame start.
- Several presses within one frame produce a single advance.

Patterns (active area only, meaning `x<ActiveW && y<ActiveH`; outside it `video` is 0):
- `PAT_BARS` (0): 8 vertical bars, each `ActiveW/8` wide. Left to right: white, yellow, cyan, green, magenta, red, blue, black. White is FFFFFF; each other bar uses FF/00 per channel. Boundaries are localparam compares, with no divider.
- `PAT_RAMP` (1): R=G=B=`x[7:0]`.
- `PAT_CHECK` (2): 32×32 squares. The pixel is white if `x[5]^y[5]`, else black.
- `PAT_BAR` (3): background is 0x111111. A white 16-pixel column covers `bar_pos <= x < bar_pos+16`, clipped at `ActiveW`.

## Timing
- Latency is exactly 1 clock: `video` in cycle N+1 reflects `x`/`y` from cycle N. `h14tx_dvo` relies on this fixed one-cycle latency.
- Reset values: `video`=0, `pattern`=`PAT_BARS`, `bar_pos`=0, `pending`=0, debounce count=0, accepted level=0, `x_q`/`y_q`=0.
- Reset takes effect at the next `clk` edge with `rst_n` low. A press in progress is discarded.
- The button-to-pattern delay is 2 sync cycles + `DebounceCycles` + 1, plus the wait until the next `frame_start`.
- Button release has no effect on `pattern`.

## Structure
- Add to `h14tx_pkg`:
  - `typedef enum logic [1:0] pattern_t {PAT_BARS, PAT_RAMP, PAT_CHECK, PAT_BAR}`.
  - Colour constants `RGB_WHITE`, `RGB_BLACK`, `RGB_BG`.
- One sub-module, `h14tx_debounce`, containing the synchroniser and counter. It is parameterised by `DebounceCycles` and outputs a one-cycle `press` pulse.
- Pattern generation is a single `always_comb` mux feeding the output register.

## Test plan
- Reset, then drive a 1280×720 raster (including blanking coordinates). Required: `video`=0 during reset; bar pattern output, with `x=0`→FFFFFF, `x=160`→FFFF00, `x=1279`→000000, each appearing one cycle after the coordinate.
- Drive `y=720`, `x=5`. Required: `video`=0.
- Run with `DebounceCycles=4`. Pulse `btn` high for 3 cycles (rejected), then hold it 10 cycles mid-frame. Required: `pattern` stays 0 until the next (0,0), then becomes 1; `x=0x4A` then gives 4A4A4A.
- Give three presses within one frame. Required: `pattern` advances by exactly 1. Starting from pattern 3, a press gives pattern 0.
- In `PAT_BAR`, run frames until the bar wraps. Required: `bar_pos` sequence 0,4,…,1276,0, and at `bar_pos`=1276 pixels 1276–1279 are white while pixel 0 is 111111.
- Make the debounced press coincide with `frame_start`. Required: the new pattern appears on the (0,0) pixel. Also assert `rst_n` mid-frame. Required: all state returns to its reset values on the next edge.

Source files
------------

// File: rtl/h14tx_pkg.sv
// h14tx_pkg: shared types and constants for the h14tx transmit path.
//   video_t   - one 8-bit colour channel
//   pattern_t - test-pattern selector (bars, ramp, checker, moving bar)
//   RGB_*     - 24-bit {R,G,B} colour constants
//   next_pattern() - cyclic successor of a pattern_t value
package h14tx_pkg;

    typedef logic [7:0] video_t;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_BAR   = 2'd3
    } pattern_t;

    localparam logic [23:0] RGB_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] RGB_BLACK   = 24'h00_00_00;
    localparam logic [23:0] RGB_BG      = 24'h11_11_11;
    localparam logic [23:0] RGB_YELLOW  = 24'hFF_FF_00;
    localparam logic [23:0] RGB_CYAN    = 24'h00_FF_FF;
    localparam logic [23:0] RGB_GREEN   = 24'h00_FF_00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF_00_FF;
    localparam logic [23:0] RGB_RED     = 24'hFF_00_00;
    localparam logic [23:0] RGB_BLUE    = 24'h00_00_FF;

    // Pattern cycle 0 -> 1 -> 2 -> 3 -> 0.
    function automatic pattern_t next_pattern(input pattern_t cur);
        pattern_t nxt;
        case (cur)
            PAT_BARS:  nxt = PAT_RAMP;
            PAT_RAMP:  nxt = PAT_CHECK;
            PAT_CHECK: nxt = PAT_BAR;
            PAT_BAR:   nxt = PAT_BARS;
            default:   nxt = PAT_BARS;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/h14tx_debounce.sv
// h14tx_debounce: 2-flop synchroniser plus stable-level debouncer for a
// push-button. Emits a single-cycle pulse when the accepted level rises.
//   clk   - pixel clock
//   rst_n - synchronous active-low reset
//   btn   - raw asynchronous button pin, high = pressed
//   press - one-cycle pulse on an accepted 0->1 transition
module h14tx_debounce #(
    parameter int DebounceCycles = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic            sync1_r;
    logic            sync2_r;
    logic            level_r;
    logic            press_r;
    logic [CntW-1:0] count_r;

    // Synchronise the pin, then count consecutive cycles that disagree with
    // the accepted level; the level flips on the DebounceCycles-th one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            count_r <= '0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (count_r == CntLast) begin
                    level_r <= sync2_r;
                    count_r <= '0;
                    // Only a rising accepted level is a press; release is silent.
                    press_r <= sync2_r;
                end else begin
                    count_r <= count_r + CntW'(1);
                end
            end else begin
                count_r <= '0;
            end
        end
    end

    assign press = press_r;

endmodule

// File: rtl/h14tx_pattgen.sv
// h14tx_pattgen: video test-pattern source feeding h14tx_dvo.
// Returns one registered RGB pixel per clock for the incoming (x,y), with a
// fixed one-cycle latency. A debounced button selects among four patterns;
// the change is applied only at the start of a frame.
//   clk     - pixel clock
//   rst_n   - synchronous active-low reset
//   btn     - raw asynchronous button, high = pressed
//   x, y    - raster coordinates from h14tx_dvo
//   video   - [2]=R, [1]=G, [0]=B, 8 bits each, registered
//   pattern - currently active pattern
module h14tx_pattgen
    import h14tx_pkg::*;
#(
    parameter int BitWidth       = 11,
    parameter int BitHeight      = 10,
    parameter int ActiveW        = 1280,
    parameter int ActiveH        = 720,
    parameter int DebounceCycles = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn,
    input  logic [BitWidth-1:0]  x,
    input  logic [BitHeight-1:0] y,
    output video_t [2:0]         video,
    output pattern_t             pattern
);

    localparam logic [31:0] ActW    = 32'(ActiveW);
    localparam logic [31:0] ActH    = 32'(ActiveH);
    // Bar boundaries as constants so no divider is built.
    localparam logic [31:0] Bar1    = 32'((ActiveW / 8) * 1);
    localparam logic [31:0] Bar2    = 32'((ActiveW / 8) * 2);
    localparam logic [31:0] Bar3    = 32'((ActiveW / 8) * 3);
    localparam logic [31:0] Bar4    = 32'((ActiveW / 8) * 4);
    localparam logic [31:0] Bar5    = 32'((ActiveW / 8) * 5);
    localparam logic [31:0] Bar6    = 32'((ActiveW / 8) * 6);
    localparam logic [31:0] Bar7    = 32'((ActiveW / 8) * 7);
    localparam logic [31:0] BarStep = 32'd4;
    localparam logic [31:0] BarWide = 32'd16;

    logic                 press_s;
    logic                 frame_start_s;
    logic                 pend_any_s;
    logic [31:0]          x_ext_s;
    logic [31:0]          y_ext_s;
    logic [31:0]          bar_ext_s;
    logic [31:0]          bar_next_ext_s;
    pattern_t             pattern_next_s;
    logic                 pending_next_s;
    logic [BitWidth-1:0]  bar_next_s;
    logic [23:0]          pixel_s;

    pattern_t             pattern_r;
    logic                 pending_r;
    logic [BitWidth-1:0]  bar_pos_r;
    logic [BitWidth-1:0]  x_q_r;
    logic [BitHeight-1:0] y_q_r;
    video_t [2:0]         video_r;

    h14tx_debounce #(
        .DebounceCycles(DebounceCycles)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .press (press_s)
    );

    assign x_ext_s        = 32'(x);
    assign y_ext_s        = 32'(y);
    assign bar_ext_s      = 32'(bar_pos_r);
    assign bar_next_ext_s = 32'(bar_next_s);

    // (0,0) that was not already (0,0) last cycle: one pulse per frame even if
    // the DVO holds the origin for several cycles.
    assign frame_start_s = (x == '0 && y == '0) && !(x_q_r == '0 && y_q_r == '0);

    // A press arriving in the frame-start cycle itself still counts.
    assign pend_any_s = pending_r | press_s;

    // Next-state pattern, pending flag and bar position.
    always_comb begin
        pattern_next_s = pattern_r;
        pending_next_s = pend_any_s;
        bar_next_s     = bar_pos_r;
        if (frame_start_s) begin
            if (pend_any_s) begin
                pattern_next_s = next_pattern(pattern_r);
                pending_next_s = 1'b0;
            end else begin
                pattern_next_s = pattern_r;
                pending_next_s = 1'b0;
            end
            if (bar_ext_s + BarStep >= ActW) begin
                bar_next_s = '0;
            end else begin
                bar_next_s = bar_pos_r + BitWidth'(4);
            end
        end else begin
            pattern_next_s = pattern_r;
            bar_next_s     = bar_pos_r;
        end
    end

    // Pixel mux; uses next-state values so the origin pixel already shows the
    // new frame's pattern and bar position.
    always_comb begin
        pixel_s = RGB_BLACK;
        if (x_ext_s < ActW && y_ext_s < ActH) begin
            case (pattern_next_s)
                PAT_BARS: begin
                    if (x_ext_s < Bar1) begin
                        pixel_s = RGB_WHITE;
                    end else if (x_ext_s < Bar2) begin
                        pixel_s = RGB_YELLOW;
                    end else if (x_ext_s < Bar3) begin
                        pixel_s = RGB_CYAN;
                    end else if (x_ext_s < Bar4) begin
                        pixel_s = RGB_GREEN;
                    end else if (x_ext_s < Bar5) begin
                        pixel_s = RGB_MAGENTA;
                    end else if (x_ext_s < Bar6) begin
                        pixel_s = RGB_RED;
                    end else if (x_ext_s < Bar7) begin
                        pixel_s = RGB_BLUE;
                    end else begin
                        pixel_s = RGB_BLACK;
                    end
                end
                PAT_RAMP:  pixel_s = {x[7:0], x[7:0], x[7:0]};
                PAT_CHECK: pixel_s = (x[5] ^ y[5]) ? RGB_WHITE : RGB_BLACK;
                PAT_BAR: begin
                    // Clipping at ActiveW is covered by the active-area test.
                    if (x_ext_s >= bar_next_ext_s && x_ext_s < bar_next_ext_s + BarWide) begin
                        pixel_s = RGB_WHITE;
                    end else begin
                        pixel_s = RGB_BG;
                    end
                end
                default:   pixel_s = RGB_BLACK;
            endcase
        end else begin
            pixel_s = RGB_BLACK;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            video_r   <= '0;
            pattern_r <= PAT_BARS;
            pending_r <= 1'b0;
            bar_pos_r <= '0;
            x_q_r     <= '0;
            y_q_r     <= '0;
        end else begin
            video_r   <= pixel_s;
            pattern_r <= pattern_next_s;
            pending_r <= pending_next_s;
            bar_pos_r <= bar_next_s;
            x_q_r     <= x;
            y_q_r     <= y;
        end
    end

    assign video   = video_r;
    assign pattern = pattern_r;

endmodule

// File: tb/tb_h14tx_pattgen.sv
// Directed self-checking bench for h14tx_pattgen (DebounceCycles = 4).
module tb_h14tx_pattgen;
    import h14tx_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         btn;
    logic [10:0]  x;
    logic [9:0]   y;
    video_t [2:0] video;
    pattern_t     pattern;

    int n_checks = 0;
    int n_errors = 0;
    // Bench-side frame-start tracking for the moving bar.
    int px = 0;
    int py = 0;
    int exp_bar = 0;
    int guard;

    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BG    = 24'h111111;

    always #5 clk = ~clk;

    h14tx_pattgen #(
        .BitWidth       (11),
        .BitHeight      (10),
        .ActiveW        (1280),
        .ActiveH        (720),
        .DebounceCycles (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .x       (x),
        .y       (y),
        .video   (video),
        .pattern (pattern)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one coordinate for one clock; return #1 after the edge.
    task automatic pix(input int xx, input int yy);
        @(negedge clk);
        x = 11'(xx);
        y = 10'(yy);
        @(posedge clk);
        if (!rst_n) begin
            px = 0;
            py = 0;
            exp_bar = 0;
        end else begin
            if (xx == 0 && yy == 0 && !(px == 0 && py == 0))
                exp_bar = (exp_bar + 4 >= 1280) ? 0 : exp_bar + 4;
            px = xx;
            py = yy;
        end
        #1;
    endtask

    task automatic check_px(input string tag, input int xx, input int yy, input logic [23:0] exp);
        pix(xx, yy);
        check_eq(tag, 32'(video), 32'(exp));
    endtask

    task automatic frame();
        pix(1279, 719);
        pix(0, 0);
    endtask

    task automatic press();
        btn = 1'b1;
        repeat (8) pix(100, 10);
        btn = 1'b0;
        repeat (8) pix(100, 10);
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 1'b0;
        x     = '0;
        y     = '0;

        // Reset: active-area coordinate would otherwise give white bars.
        pix(5, 5);
        pix(5, 5);
        check_eq("rst_video", 32'(video), 32'h0);
        check_eq("rst_pattern", 32'(pattern), 32'(PAT_BARS));
        rst_n = 1'b1;

        // Colour bars, one-cycle latency.
        pix(1279, 719);
        pix(0, 0);
        check_eq("bars_x0", 32'(video), 32'hFFFFFF);
        check_px("bars_x159", 159, 1, 24'hFFFFFF);
        check_px("bars_x160", 160, 1, 24'hFFFF00);
        check_px("bars_x320", 320, 1, 24'h00FFFF);
        check_px("bars_x480", 480, 1, 24'h00FF00);
        check_px("bars_x1119", 1119, 1, 24'h0000FF);
        check_px("bars_x1279", 1279, 1, 24'h000000);
        check_px("blank_x1280", 1280, 1, 24'h000000);
        check_px("blank_y720", 5, 720, 24'h000000);

        // Short pulse rejected.
        btn = 1'b1;
        repeat (3) pix(100, 10);
        btn = 1'b0;
        repeat (6) pix(100, 10);
        frame();
        check_eq("reject_short", 32'(pattern), 32'(PAT_BARS));

        // Accepted press waits for the frame boundary; release has no effect.
        btn = 1'b1;
        repeat (10) pix(100, 10);
        btn = 1'b0;
        repeat (8) pix(100, 10);
        check_eq("hold_mid_frame", 32'(pattern), 32'(PAT_BARS));
        pix(1279, 719);
        check_eq("hold_before_origin", 32'(pattern), 32'(PAT_BARS));
        pix(0, 0);
        check_eq("advance_ramp", 32'(pattern), 32'(PAT_RAMP));
        check_eq("ramp_x0", 32'(video), 32'h000000);
        check_px("ramp_4a", 8'h4A, 3, 24'h4A4A4A);

        // Three presses in one frame advance by one.
        press();
        press();
        press();
        frame();
        check_eq("multi_press", 32'(pattern), 32'(PAT_CHECK));
        check_px("check_32_0", 32, 0, WHITE);
        check_px("check_32_32", 32, 32, 24'h000000);
        check_px("check_0_32", 0, 32, WHITE);
        check_px("check_31_0", 31, 0, 24'h000000);

        press();
        frame();
        check_eq("to_bar", 32'(pattern), 32'(PAT_BAR));
        press();
        frame();
        check_eq("wrap_3_to_0", 32'(pattern), 32'(PAT_BARS));
        press(); frame();
        press(); frame();
        press(); frame();
        check_eq("back_to_bar", 32'(pattern), 32'(PAT_BAR));
        check_px("bar_bg", (exp_bar + 640) % 1280, 5, BG);

        // Walk the bar to its last position.
        guard = 0;
        while (exp_bar != 1276 && guard < 400) begin
            frame();
            check_px("bar_lead", exp_bar, 5, WHITE);
            if (exp_bar + 16 < 1280)
                check_px("bar_trail", exp_bar + 16, 5, BG);
            guard++;
        end
        for (int i = 1276; i < 1280; i++)
            check_px("bar_clip_white", i, 5, WHITE);
        check_px("bar_1275", 1275, 5, BG);
        check_px("bar_x0_bg", 0, 5, BG);
        check_px("bar_blank", 1280, 5, 24'h000000);
        frame();
        check_eq("bar_wrap_origin", 32'(video), 32'hFFFFFF);
        check_px("bar_wrap_15", 15, 5, WHITE);
        check_px("bar_wrap_16", 16, 5, BG);

        // Debounced press lands in the frame-start cycle.
        btn = 1'b1;
        repeat (5) pix(100, 10);
        pix(1279, 719);
        check_eq("coinc_before", 32'(pattern), 32'(PAT_BAR));
        pix(0, 0);
        check_eq("coinc_pattern", 32'(pattern), 32'(PAT_BARS));
        check_eq("coinc_pixel", 32'(video), 32'hFFFFFF);
        btn = 1'b0;
        repeat (8) pix(100, 10);
        frame();
        check_eq("coinc_no_leftover", 32'(pattern), 32'(PAT_BARS));

        // Mid-frame reset clears pattern, pending press, bar and a press in progress.
        press();
        frame();
        check_eq("pre_reset", 32'(pattern), 32'(PAT_RAMP));
        press();
        btn = 1'b1;
        repeat (3) pix(200, 10);
        rst_n = 1'b0;
        pix(200, 10);
        check_eq("rst_mid_video", 32'(video), 32'h0);
        check_eq("rst_mid_pattern", 32'(pattern), 32'(PAT_BARS));
        btn = 1'b0;
        rst_n = 1'b1;
        repeat (10) pix(200, 10);
        frame();
        check_eq("rst_discard", 32'(pattern), 32'(PAT_BARS));
        press(); frame();
        press(); frame();
        press(); frame();
        check_eq("rst_to_bar", 32'(pattern), 32'(PAT_BAR));
        check_px("rst_bar_lead", exp_bar, 5, WHITE);
        check_px("rst_bar_before", exp_bar - 1, 5, BG);
        check_px("rst_bar_end", exp_bar + 15, 5, WHITE);
        check_px("rst_bar_after", exp_bar + 16, 5, BG);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
